// File: rtl/weight_update_pkg.sv
// Shared constants, types and FSM encoding for the weight-update block.
package weight_update_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_ELEM = 8;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef data_t [N_ELEM-1:0]       arr_t;

  localparam data_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam data_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    FINISH
  } state_t;

endpackage

// File: rtl/weight_update_if.sv
// Weight-update bus: delta/init vectors and requests in, stored weights and status out.
interface weight_update_if #(
  parameter int unsigned N_ELEM = weight_update_pkg::N_ELEM,
  parameter int unsigned DATA_W = weight_update_pkg::DATA_W
);

  logic [N_ELEM-1:0][DATA_W-1:0] delta_w_in;
  logic                          apply;
  logic                          init_load;
  logic [N_ELEM-1:0][DATA_W-1:0] init_w;
  logic [N_ELEM-1:0][DATA_W-1:0] w_out;
  logic                          busy;
  logic                          done;
  logic                          sat;

  modport master (
    output delta_w_in, apply, init_load, init_w,
    input  w_out, busy, done, sat
  );

  modport slave (
    input  delta_w_in, apply, init_load, init_w,
    output w_out, busy, done, sat
  );

endinterface

// File: rtl/weight_update_sat_add.sv
// Combinational signed adder that clamps to the DATA_W two's-complement range.
module sat_add #(
  parameter int unsigned DATA_W = weight_update_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_sat
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum = {i_a[DATA_W-1], i_a} + {i_b[DATA_W-1], i_b};
    // Overflow when the extra sign bit disagrees with the result sign bit.
    o_sat = w_sum[DATA_W] ^ w_sum[DATA_W-1];
    if (!o_sat)
      o_sum = w_sum[DATA_W-1:0];
    else if (w_sum[DATA_W])
      o_sum = {1'b1, {(DATA_W-1){1'b0}}};
    else
      o_sum = {1'b0, {(DATA_W-1){1'b1}}};
  end

endmodule

// File: rtl/weight_update.sv
// Weight register file updated one element per cycle with saturating deltas.
module weight_update #(
  parameter int unsigned N_ELEM = weight_update_pkg::N_ELEM,
  parameter int unsigned DATA_W = weight_update_pkg::DATA_W
) (
  input  logic            CLK,
  input  logic            RST_N,
  weight_update_if.slave  bus
);

  import weight_update_pkg::*;

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic [IDX_W-1:0]              r_idx;
  logic [N_ELEM-1:0][DATA_W-1:0] r_w;
  logic [N_ELEM-1:0][DATA_W-1:0] r_delta;
  logic                          r_sat_work;
  logic                          r_sat;
  logic [DATA_W-1:0]             w_cur_w;
  logic [DATA_W-1:0]             w_cur_d;
  logic [DATA_W-1:0]             w_sum;
  logic                          w_clamp;
  logic                          w_last;
  logic                          w_busy;
  logic                          w_done;

  assign w_cur_w = r_w[r_idx];
  assign w_cur_d = r_delta[r_idx];
  assign w_last  = (r_idx == LAST_IDX);

  sat_add #(.DATA_W(DATA_W)) u_sat_add (
    .i_a   (w_cur_w),
    .i_b   (w_cur_d),
    .o_sum (w_sum),
    .o_sat (w_clamp)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (!bus.init_load && bus.apply) w_next = UPDATE;
      end
      UPDATE: if (w_last) w_next = FINISH;
      FINISH: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx      <= '0;
      r_w        <= '0;
      r_delta    <= '0;
      r_sat_work <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.init_load) begin
            r_w   <= bus.init_w;
            r_sat <= 1'b0;
          end else if (bus.apply) begin
            r_delta    <= bus.delta_w_in;
            r_idx      <= '0;
            r_sat_work <= 1'b0;
          end
        end
        UPDATE: begin
          r_w[r_idx] <= w_sum;
          if (w_clamp) r_sat_work <= 1'b1;
          // Index parks on the last element rather than wrapping.
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        FINISH: r_sat <= r_sat_work;
        default: ;
      endcase
    end
  end

  assign bus.w_out = r_w;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.sat   = r_sat;

endmodule

// File: tb/tb_weight_update.sv
// Directed self-checking bench for weight_update.
module tb_weight_update;

  import weight_update_pkg::*;

  localparam int unsigned N  = N_ELEM;
  localparam int unsigned D  = DATA_W;
  localparam int unsigned VW = N * D;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  weight_update_if #(.N_ELEM(N), .DATA_W(D)) wu ();

  weight_update #(.N_ELEM(N), .DATA_W(D)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (wu.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic arr_t fill(input logic [D-1:0] v);
    arr_t f;
    for (int i = 0; i < int'(N); i++) f[i] = v;
    return f;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input arr_t v);
    wu.init_w    = v;
    wu.init_load = 1'b1;
    step();
    wu.init_load = 1'b0;
  endtask

  // Accepts an apply on the next edge, then steps until done (bounded).
  task automatic run_update(input arr_t delta, output int unsigned edges);
    wu.delta_w_in = delta;
    wu.apply      = 1'b1;
    step();
    wu.apply = 1'b0;
    edges    = 1;
    while (!wu.done && edges < 40) begin
      step();
      edges++;
    end
  endtask

  arr_t        exp_v;
  arr_t        init_v;
  arr_t        delta_v;
  int unsigned edges;
  int unsigned pulses;

  initial begin
    wu.delta_w_in = '0;
    wu.apply      = 1'b0;
    wu.init_load  = 1'b0;
    wu.init_w     = '0;

    #12;
    check_eq("rst_w_out", wu.w_out, '0);
    check_eq("rst_busy", VW'(wu.busy), '0);
    check_eq("rst_done", VW'(wu.done), '0);
    check_eq("rst_sat", VW'(wu.sat), '0);
    RST_N = 1'b1;

    // Init load takes one edge and never raises busy
    load(fill(16'h0100));
    check_eq("init_w_out", wu.w_out, fill(16'h0100));
    check_eq("init_busy", VW'(wu.busy), '0);

    // 0x0100 + 0xFF80 = 0x0080, done 9 edges after the accepting edge inclusive
    run_update(fill(16'hFF80), edges);
    check_eq("neg_delta_edges", VW'(edges), VW'(N + 1));
    check_eq("neg_delta_w_out", wu.w_out, fill(16'h0080));
    step();
    check_eq("neg_delta_sat", VW'(wu.sat), '0);
    check_eq("neg_delta_idle", VW'({wu.busy, wu.done}), '0);

    // Positive clamp on element 3, negative clamp on element 5
    init_v = fill(16'h0100);
    init_v[3] = 16'h7F00;
    init_v[5] = 16'h8100;
    load(init_v);
    delta_v = fill(16'h0010);
    delta_v[3] = 16'h0200;
    delta_v[5] = 16'h8000;
    exp_v = fill(16'h0110);
    exp_v[3] = 16'h7FFF;
    exp_v[5] = 16'h8000;
    run_update(delta_v, edges);
    check_eq("clamp_edges", VW'(edges), VW'(N + 1));
    check_eq("clamp_w_out", wu.w_out, exp_v);
    step();
    check_eq("clamp_sat", VW'(wu.sat), VW'(1));
    step();
    step();
    check_eq("clamp_sat_hold", VW'(wu.sat), VW'(1));
    load(fill(16'h0010));
    check_eq("init_clears_sat", VW'(wu.sat), '0);

    // Re-applied apply, changed delta and init_load while busy are all ignored
    wu.delta_w_in = fill(16'h0001);
    wu.apply      = 1'b1;
    step();
    check_eq("busy_after_accept", VW'(wu.busy), VW'(1));
    wu.delta_w_in = fill(16'h0100);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin
        wu.init_w    = fill(16'hAAAA);
        wu.init_load = 1'b1;
      end
      if (i == 2) wu.init_load = 1'b0;
      step();
      if (wu.done) begin
        pulses++;
        wu.apply = 1'b0;
      end
    end
    check_eq("busy_done_pulses", VW'(pulses), VW'(1));
    check_eq("busy_latched_delta", wu.w_out, fill(16'h0011));
    check_eq("busy_back_idle", VW'(wu.busy), '0);

    // init_load wins over simultaneous apply; the apply is dropped
    wu.init_w     = fill(16'h0222);
    wu.delta_w_in = fill(16'h0001);
    wu.init_load  = 1'b1;
    wu.apply      = 1'b1;
    step();
    wu.init_load = 1'b0;
    wu.apply     = 1'b0;
    check_eq("prio_w_out", wu.w_out, fill(16'h0222));
    check_eq("prio_busy", VW'(wu.busy), '0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wu.done || wu.busy) pulses++;
    end
    check_eq("prio_no_update", VW'(pulses), '0);
    check_eq("prio_w_hold", wu.w_out, fill(16'h0222));

    // Reset after element 4 is written abandons the update
    load(fill(16'h0100));
    wu.delta_w_in = fill(16'h0001);
    wu.apply      = 1'b1;
    step();
    wu.apply = 1'b0;
    repeat (5) step();
    exp_v = fill(16'h0100);
    for (int i = 0; i < 5; i++) exp_v[i] = 16'h0101;
    check_eq("partial_w_out", wu.w_out, exp_v);
    #2 RST_N = 1'b0;
    #1;
    check_eq("async_rst_w_out", wu.w_out, '0);
    check_eq("async_rst_status", VW'({wu.busy, wu.done, wu.sat}), '0);
    pulses = 0;
    repeat (2) begin
      step();
      if (wu.done) pulses++;
    end
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wu.done || wu.busy) pulses++;
    end
    check_eq("rst_no_done", VW'(pulses), '0);
    check_eq("rst_w_stays_zero", wu.w_out, '0);
    run_update(fill(16'h0005), edges);
    check_eq("post_rst_edges", VW'(edges), VW'(N + 1));
    check_eq("post_rst_w_out", wu.w_out, fill(16'h0005));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_update.md
WEIGHT_UPDATE -- requirements
Module: weight_update

Interface
REQ-001 Parameter: N_ELEM, default 8, number of elements in ARR (weight vector length).
REQ-002 Parameter: DATA_W, default 16, width of one data element; signed two's complement.
REQ-003 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: RST_N  input  1  reset, asynchronous and active-low.
REQ-005 Port: delta_w_in  input  ARR  signed per-element weight delta from the delta-weight generator.
REQ-006 Port: apply  input  1  single-cycle request to add delta_w_in to the stored weights.
REQ-007 Port: init_load  input  1  request to overwrite all stored weights with init_w.
REQ-008 Port: init_w  input  ARR  initial weight vector.
REQ-009 Port: w_out  output  ARR  current stored weight vector, registered.
REQ-010 Port: busy  output  1  high while an update is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when an update completes.
REQ-012 Port: sat  output  1  high if any element saturated during the last completed update.

Function
REQ-013 FSM states SHALL be IDLE, UPDATE and FINISH.
REQ-014 In IDLE, apply=1 SHALL snapshot delta_w_in into an internal register, clear the element index to 0, clear the working saturation flag and enter UPDATE.
REQ-015 In IDLE, init_load=1 SHALL copy init_w into the weight registers in one cycle and clear sat; init_load SHALL take priority over a simultaneous apply, and that apply SHALL be dropped.
REQ-016 In UPDATE, exactly one element per cycle SHALL be updated: w[idx] <= sat_add(w[idx], delta[idx]); idx SHALL then increment.
REQ-017 sat_add SHALL be a DATA_W+1-bit signed sum clamped to +(2^(DATA_W-1)-1) on positive overflow and -2^(DATA_W-1) on negative overflow; any clamp SHALL set the working saturation flag.
REQ-018 After the element at idx = N_ELEM-1 is written, the FSM SHALL enter FINISH; idx SHALL NOT wrap back to 0 within the update.
REQ-019 In FINISH, done SHALL be 1 for exactly one cycle, sat SHALL take the working saturation flag, and the FSM SHALL return to IDLE.
REQ-020 busy SHALL be 1 in UPDATE and FINISH, 0 in IDLE.
REQ-021 Latency: with apply accepted at edge t, element k SHALL be written at edge t+1+k, and done SHALL be high in the cycle after edge t+N_ELEM.
REQ-022 apply and init_load SHALL be ignored while busy=1; they SHALL NOT be queued.
REQ-023 Changes to delta_w_in after acceptance SHALL NOT affect the update in progress.
REQ-024 w_out SHALL reflect each element's write immediately after its edge, so partially updated vectors are visible while busy=1.
REQ-025 sat SHALL hold its value until the next FINISH or init_load.

Reset
REQ-026 RST_N=0 SHALL immediately force: state IDLE, idx 0, all weights 0, delta snapshot 0, busy 0, done 0, sat 0.
REQ-027 Reset asserted mid-update SHALL abandon the update with no done pulse, leaving all weights 0.
REQ-028 After RST_N deasserts, the first rising edge SHALL accept apply or init_load.

Structure
REQ-029 DATA_W, N_ELEM, the data and ARR typedefs, and the saturation limit constants SHALL live in the shared library package.
REQ-030 The saturating adder SHALL be a separate sub-module, sat_add, that is combinational and parameterised by DATA_W.
REQ-031 The FSM, index counter and register arrays SHALL reside in weight_update itself.

Verification
REQ-032 Reset, then init_load with init_w all 0x0100 -> w_out all 0x0100 after one edge; busy stays 0.
REQ-033 Weights all 0x0100, apply with delta all 0xFF80 (-0.5 in Q8.8) -> done after 9 edges, w_out all 0x0080, sat 0.
REQ-034 Weight element 3 = 0x7F00, delta element 3 = 0x0200 -> element 3 = 0x7FFF, sat 1; other elements updated normally.
REQ-035 Assert apply again on the cycle after acceptance and change delta_w_in mid-update -> exactly one done pulse, and the result uses the originally latched delta.
REQ-036 Assert init_load and apply in the same IDLE cycle -> init_w loaded, no update, no done pulse.
REQ-037 Pull RST_N low after element 4 is written -> w_out all 0 asynchronously, no done pulse, and the next apply completes normally.
